// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg
// Shared constants for the UART command controller: framing bytes,
// command-parser state encodings and response-sequencer state encodings.
package uart_cmd_ctrl_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h55;
    localparam logic [7:0] ACK_BYTE = 8'h06;
    localparam logic [7:0] NAK_BYTE = 8'h15;

    // Parser states
    // state  | meaning
    // P_IDLE | hunting for SOF, other bytes dropped
    // P_CMD  | next byte is the command
    // P_LEN  | next byte is the payload length
    // P_DATA | collecting payload bytes
    // P_CHK  | next byte is the XOR checksum
    localparam logic [2:0] P_IDLE = 3'd0;
    localparam logic [2:0] P_CMD  = 3'd1;
    localparam logic [2:0] P_LEN  = 3'd2;
    localparam logic [2:0] P_DATA = 3'd3;
    localparam logic [2:0] P_CHK  = 3'd4;

    // Response sequencer states
    // state  | meaning
    // T_IDLE | waiting for a pending response and a free transmitter
    // T_SEND | strobe issued, waiting for the transmitter to go busy
    // T_WAIT | transmitter busy, waiting for its done pulse
    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_SEND = 2'd1;
    localparam logic [1:0] T_WAIT = 2'd2;

endpackage

// File: rtl/uart_rsp_seq.sv
// uart_rsp_seq
// Hands ACK/NAK response bytes to the UART transmitter one at a time.
// Ports:
//   i_Clock, i_Rst_L      clock, async active-low reset
//   i_Rsp_Req, i_Rsp_Byte one-cycle request to queue a response byte
//   i_TX_Active           transmitter busy
//   i_TX_Done             transmitter finished a byte (may last several cycles)
//   o_TX_DV, o_TX_Byte    one-cycle send strobe and the byte to send
module uart_rsp_seq
    import uart_cmd_ctrl_pkg::*;
(
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_Rsp_Req,
    input  logic [7:0] i_Rsp_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte
);

    logic [1:0] r_state;
    logic       r_pend;
    logic [7:0] r_pend_byte;
    logic       r_done_d;
    logic       r_tx_dv;
    logic [7:0] r_tx_byte;
    logic       w_done_rise;

    // Completion is taken on the rising edge of Done so a multi-cycle Done
    // pulse retires exactly one byte.
    assign w_done_rise = i_TX_Done & ~r_done_d;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state     <= T_IDLE;
            r_pend      <= 1'b0;
            r_pend_byte <= 8'h00;
            r_done_d    <= 1'b0;
            r_tx_dv     <= 1'b0;
            r_tx_byte   <= 8'h00;
        end else begin
            r_tx_dv  <= 1'b0;
            r_done_d <= i_TX_Done;
            case (r_state)
                T_IDLE: begin
                    if (r_pend && !i_TX_Active) begin
                        r_tx_dv   <= 1'b1;
                        r_tx_byte <= r_pend_byte;
                        r_pend    <= 1'b0;
                        r_state   <= T_SEND;
                    end
                end
                T_SEND: begin
                    if (i_TX_Active) begin
                        r_state <= T_WAIT;
                    end
                end
                T_WAIT: begin
                    if (w_done_rise) begin
                        r_state <= T_IDLE;
                    end
                end
                default: r_state <= T_IDLE;
            endcase
            // A new request replaces any response not yet strobed; the byte
            // already handed to the transmitter lives in r_tx_byte.
            if (i_Rsp_Req) begin
                r_pend      <= 1'b1;
                r_pend_byte <= i_Rsp_Byte;
            end
        end
    end

    assign o_TX_DV   = r_tx_dv;
    assign o_TX_Byte = r_tx_byte;

endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
// Parses SOF/CMD/LEN/payload/CHK frames from a UART receiver, streams the
// payload out, flags good/bad frames and answers each frame with ACK or NAK.
// Ports:
//   i_Clock, i_Rst_L          clock, async active-low reset
//   i_RX_DV, i_RX_Byte        received byte strobe and data
//   o_TX_DV, o_TX_Byte        response send strobe and byte
//   i_TX_Active, i_TX_Done    transmitter status
//   o_Data_DV, o_Data_Byte    payload byte strobe and data
//   o_Cmd_Valid               frame passed checksum
//   o_Cmd, o_Len              command and length of the last frame
//   o_Err                     checksum, length or timeout error
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CLKS = 8680,
    parameter int MAX_LEN      = 15
) (
    input  logic       i_Clock,
    input  logic       i_Rst_L,
    input  logic       i_RX_DV,
    input  logic [7:0] i_RX_Byte,
    output logic       o_TX_DV,
    output logic [7:0] o_TX_Byte,
    input  logic       i_TX_Active,
    input  logic       i_TX_Done,
    output logic       o_Data_DV,
    output logic [7:0] o_Data_Byte,
    output logic       o_Cmd_Valid,
    output logic [7:0] o_Cmd,
    output logic [3:0] o_Len,
    output logic       o_Err
);

    localparam int             TO_W      = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]     MAX_LEN_B = 8'(MAX_LEN);

    logic [2:0]      r_p_state;
    logic [7:0]      r_cmd;
    logic [3:0]      r_len;
    logic [7:0]      r_xor;
    logic [3:0]      r_cnt;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_data_dv;
    logic [7:0]      r_data_byte;
    logic            r_cmd_valid;
    logic            r_err;
    logic            r_rsp_req;
    logic [7:0]      r_rsp_byte;

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_p_state   <= P_IDLE;
            r_cmd       <= 8'h00;
            r_len       <= 4'h0;
            r_xor       <= 8'h00;
            r_cnt       <= 4'h0;
            r_to_cnt    <= '0;
            r_data_dv   <= 1'b0;
            r_data_byte <= 8'h00;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_req   <= 1'b0;
            r_rsp_byte  <= 8'h00;
        end else begin
            r_data_dv   <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rsp_req   <= 1'b0;
            if (i_RX_DV) begin
                r_to_cnt <= '0;
                case (r_p_state)
                    P_IDLE: begin
                        if (i_RX_Byte == SOF_BYTE) begin
                            r_p_state <= P_CMD;
                        end
                    end
                    P_CMD: begin
                        r_cmd     <= i_RX_Byte;
                        r_xor     <= i_RX_Byte;
                        r_p_state <= P_LEN;
                    end
                    P_LEN: begin
                        if (i_RX_Byte > MAX_LEN_B) begin
                            r_err      <= 1'b1;
                            r_rsp_req  <= 1'b1;
                            r_rsp_byte <= NAK_BYTE;
                            r_p_state  <= P_IDLE;
                        end else begin
                            r_len     <= i_RX_Byte[3:0];
                            r_xor     <= r_xor ^ i_RX_Byte;
                            r_cnt     <= 4'h0;
                            r_p_state <= (i_RX_Byte == 8'h00) ? P_CHK : P_DATA;
                        end
                    end
                    P_DATA: begin
                        r_data_dv   <= 1'b1;
                        r_data_byte <= i_RX_Byte;
                        r_xor       <= r_xor ^ i_RX_Byte;
                        r_cnt       <= r_cnt + 4'd1;
                        if ((r_cnt + 4'd1) == r_len) begin
                            r_p_state <= P_CHK;
                        end
                    end
                    P_CHK: begin
                        r_rsp_req <= 1'b1;
                        if (i_RX_Byte == r_xor) begin
                            r_cmd_valid <= 1'b1;
                            r_rsp_byte  <= ACK_BYTE;
                        end else begin
                            r_err      <= 1'b1;
                            r_rsp_byte <= NAK_BYTE;
                        end
                        r_p_state <= P_IDLE;
                    end
                    default: r_p_state <= P_IDLE;
                endcase
            end else if (r_p_state != P_IDLE) begin
                if (r_to_cnt == TO_LAST) begin
                    r_err      <= 1'b1;
                    r_rsp_req  <= 1'b1;
                    r_rsp_byte <= NAK_BYTE;
                    r_p_state  <= P_IDLE;
                    r_to_cnt   <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end
        end
    end

    uart_rsp_seq u_rsp_seq (
        .i_Clock     (i_Clock),
        .i_Rst_L     (i_Rst_L),
        .i_Rsp_Req   (r_rsp_req),
        .i_Rsp_Byte  (r_rsp_byte),
        .i_TX_Active (i_TX_Active),
        .i_TX_Done   (i_TX_Done),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte)
    );

    assign o_Data_DV   = r_data_dv;
    assign o_Data_Byte = r_data_byte;
    assign o_Cmd_Valid = r_cmd_valid;
    assign o_Cmd       = r_cmd;
    assign o_Len       = r_len;
    assign o_Err       = r_err;

endmodule
